// File: rtl/regmap_write_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regmap_write_arbiter
//
// Purpose:
//   Shares the single write port of the accelerator register map between the
//   CPU MMIO store path and the accelerator engine writeback. It arbitrates
//   round-robin, lets the CPU lock out the accelerator, and checks the address
//   range and the CPU-only control registers. Every output is registered, so
//   reg_write/write_reg/write_data can drive the register map directly.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cpu_req/addr/wdata          CPU write request, held until cpu_ack
//   cpu_lock                    1 = accelerator requests are not eligible
//   cpu_ack, cpu_err            one-cycle completion pulse, error flag
//   acc_req/addr/wdata          accelerator write request, held until acc_ack
//   acc_ack, acc_err            one-cycle completion pulse, error flag
//   reg_write/write_reg/data    register-map write port
//   last_grant                  0 = CPU, 1 = accelerator; last requester served
//
// Handshake (both requesters): a requester raises req with addr/wdata and
// holds all three stable until it sees ack. The ack is a single-cycle pulse
// one cycle after the grant. err is valid only while ack is high. A requester
// whose ack is high is not eligible in that cycle, so the still-held request
// cannot be granted twice.
// ---------------------------------------------------------------------------
module regmap_write_arbiter #(
    parameter int NUM_REGS  = 48,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int CTRL_REGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lock,
    output logic              cpu_ack,
    output logic              cpu_err,
    input  logic              acc_req,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_ack,
    output logic              acc_err,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              last_grant
);

    // Limits are widened by one bit so that NUM_REGS == 2**ADDR_W still fits.
    localparam logic [ADDR_W:0] NUM_REGS_W  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] CTRL_REGS_W = (ADDR_W+1)'(CTRL_REGS);

    // Round-robin pointer: 0 = CPU preferred on contention, 1 = accelerator.
    logic              rr_ptr;

    logic              cpu_elig;
    logic              acc_elig;
    logic              grant_cpu;
    logic              grant_acc;
    logic              grant_any;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_range_bad;
    logic              win_prot_bad;
    logic              win_ok;

    always_comb begin
        cpu_elig  = cpu_req & ~cpu_ack;
        acc_elig  = acc_req & ~acc_ack & ~cpu_lock;

        // A lone eligible requester always wins; rr_ptr only breaks ties.
        grant_cpu = cpu_elig & (~acc_elig | ~rr_ptr);
        grant_acc = acc_elig & (~cpu_elig |  rr_ptr);
        grant_any = grant_cpu | grant_acc;

        win_addr  = grant_acc ? acc_addr  : cpu_addr;
        win_data  = grant_acc ? acc_wdata : cpu_wdata;

        win_range_bad = ({1'b0, win_addr} >= NUM_REGS_W);
        win_prot_bad  = grant_acc & ({1'b0, win_addr} < CTRL_REGS_W);
        win_ok        = grant_any & ~win_range_bad & ~win_prot_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            acc_ack    <= 1'b0;
            acc_err    <= 1'b0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            last_grant <= 1'b0;
        end else begin
            cpu_ack   <= grant_cpu;
            cpu_err   <= grant_cpu & ~win_ok;
            acc_ack   <= grant_acc;
            acc_err   <= grant_acc & ~win_ok;
            reg_write <= win_ok;

            // Address/data only move on a real write; rejected requests leave
            // the last written address and data visible.
            if (win_ok) begin
                write_reg  <= win_addr;
                write_data <= win_data;
            end

            // Rejected requests still count as a grant for fairness.
            if (grant_any) begin
                last_grant <= grant_acc;
                rr_ptr     <= ~grant_acc;
            end
        end
    end

endmodule

// File: tb/tb_regmap_write_arbiter.sv
`timescale 1ns/1ps
module tb_regmap_write_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int VW = 5 + AW + DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_lock, acc_req;
  logic [AW-1:0] cpu_addr, acc_addr;
  logic [DW-1:0] cpu_wdata, acc_wdata;
  logic          cpu_ack, cpu_err, acc_ack, acc_err, reg_write, last_grant;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;

  regmap_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_lock   (cpu_lock),
    .cpu_ack    (cpu_ack),
    .cpu_err    (cpu_err),
    .acc_req    (acc_req),
    .acc_addr   (acc_addr),
    .acc_wdata  (acc_wdata),
    .acc_ack    (acc_ack),
    .acc_err    (acc_err),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .last_grant (last_grant)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {cpu_ack, cpu_err, acc_ack, acc_err, reg_write,
                    write_reg, write_data, last_grant};

  int vectors = 0;
  int miscompares = 0;

  // ---------------- scoreboard model ----------------
  // Predicts the registered outputs for every clock edge from the inputs the
  // bench drove, and queues them for the checker.
  logic [VW-1:0] exp_q[$];

  logic          m_cpu_ack, m_cpu_err, m_acc_ack, m_acc_err, m_reg_write;
  logic          m_last, m_rr;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin : model
    logic          ce, ae, use_cpu, use_acc, bad, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] n_reg;
    logic [DW-1:0] n_data;
    logic          n_last, n_rr;
    if (!rst_n) begin
      m_cpu_ack   <= 1'b0;
      m_cpu_err   <= 1'b0;
      m_acc_ack   <= 1'b0;
      m_acc_err   <= 1'b0;
      m_reg_write <= 1'b0;
      m_last      <= 1'b0;
      m_rr        <= 1'b0;
      m_reg       <= '0;
      m_data      <= '0;
      exp_q.delete();
    end else begin
      ce = cpu_req && !m_cpu_ack;
      ae = acc_req && !m_acc_ack && !cpu_lock;
      if (ce && ae) begin
        use_acc = m_rr;
        use_cpu = !m_rr;
      end else begin
        use_acc = ae;
        use_cpu = ce;
      end
      a = use_acc ? acc_addr : cpu_addr;
      d = use_acc ? acc_wdata : cpu_wdata;
      bad = (int'(a) >= 48) || (use_acc && int'(a) < 8);
      wr = (use_cpu || use_acc) && !bad;
      n_reg  = wr ? a : m_reg;
      n_data = wr ? d : m_data;
      n_last = (use_cpu || use_acc) ? use_acc : m_last;
      n_rr   = (use_cpu || use_acc) ? !use_acc : m_rr;
      exp_q.push_back({use_cpu, use_cpu && bad, use_acc, use_acc && bad, wr,
                       n_reg, n_data, n_last});
      m_cpu_ack   <= use_cpu;
      m_cpu_err   <= use_cpu && bad;
      m_acc_ack   <= use_acc;
      m_acc_err   <= use_acc && bad;
      m_reg_write <= wr;
      m_reg       <= n_reg;
      m_data      <= n_data;
      m_last      <= n_last;
      m_rr        <= n_rr;
    end
  end

  // ---------------- checker / driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Waits for the next falling edge and compares the full output vector with
  // the oldest scoreboard entry.
  task automatic step(input string tag);
    logic [VW-1:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 64'(dut_vec), 64'(e));
    end
  endtask

  task automatic set_cpu(input logic req, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_acc(input logic req, input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_req = req; acc_addr = a; acc_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    int n_cpu;
    int n_acc;
    rst_n = 1'b0;
    cpu_lock = 1'b0;
    set_cpu(1'b1, 6'd1, 32'h0000_0011);
    set_acc(1'b1, 6'd9, 32'h0000_0022);

    // Reset held with both requests up: everything stays 0.
    repeat (2) @(posedge clk);
    #1 chk("rst_hold", 64'(dut_vec), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: 4 requests each, grants alternate CPU first.
    n_cpu = 0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step("contend");
      chk("cont_cpu_ack", 64'(cpu_ack), 64'(i % 2 == 0));
      chk("cont_acc_ack", 64'(acc_ack), 64'(i % 2 == 1));
      chk("cont_last", 64'(last_grant), 64'(i % 2));
      if (cpu_ack) begin
        n_cpu++;
        if (n_cpu == 4) cpu_req = 1'b0;
        else set_cpu(1'b1, 6'($urandom_range(0, 47)), $urandom);
      end
      if (acc_ack) begin
        n_acc++;
        if (n_acc == 4) acc_req = 1'b0;
        else set_acc(1'b1, 6'($urandom_range(8, 47)), $urandom);
      end
    end
    step("idle0");

    // CPU alone.
    set_cpu(1'b1, 6'd5, 32'hDEAD_BEEF);
    step("cpu_alone");
    chk("cpu_wr", 64'(reg_write), 64'd1);
    chk("cpu_reg", 64'(write_reg), 64'd5);
    chk("cpu_data", 64'(write_data), 64'hDEAD_BEEF);
    chk("cpu_ack", 64'(cpu_ack), 64'd1);
    chk("cpu_err", 64'(cpu_err), 64'd0);
    cpu_req = 1'b0;
    step("cpu_pulse");
    chk("pulse_ack", 64'(cpu_ack), 64'd0);
    chk("pulse_wr", 64'(reg_write), 64'd0);
    chk("hold_reg", 64'(write_reg), 64'd5);

    // Protection of control registers.
    set_acc(1'b1, 6'd3, 32'h0000_AAAA);
    step("acc_prot");
    chk("prot_ack", 64'(acc_ack), 64'd1);
    chk("prot_err", 64'(acc_err), 64'd1);
    chk("prot_wr", 64'(reg_write), 64'd0);
    acc_req = 1'b0;
    step("idle1");
    set_acc(1'b1, 6'd8, 32'h0000_8888);
    step("acc_8");
    chk("acc8_wr", 64'(reg_write), 64'd1);
    chk("acc8_reg", 64'(write_reg), 64'd8);
    acc_req = 1'b0;
    step("idle2");
    set_cpu(1'b1, 6'd3, 32'h0000_3333);
    step("cpu_3");
    chk("cpu3_wr", 64'(reg_write), 64'd1);
    chk("cpu3_err", 64'(cpu_err), 64'd0);
    cpu_req = 1'b0;
    step("idle3");

    // Range errors on both sides; last grant was CPU, so acc goes first.
    set_cpu(1'b1, 6'd48, 32'h4848_4848);
    set_acc(1'b1, 6'd63, 32'h6363_6363);
    step("range_acc");
    chk("range_acc_err", 64'(acc_err), 64'd1);
    chk("range_acc_wr", 64'(reg_write), 64'd0);
    chk("range_hold", 64'(write_reg), 64'd3);
    acc_req = 1'b0;
    step("range_cpu");
    chk("range_cpu_err", 64'(cpu_err), 64'd1);
    chk("range_last", 64'(last_grant), 64'd0);
    cpu_req = 1'b0;
    step("idle4");

    // Lock keeps the accelerator out.
    cpu_lock = 1'b1;
    set_acc(1'b1, 6'd10, 32'h0000_1010);
    for (int i = 0; i < 10; i++) begin
      step("locked");
      chk("locked_ack", 64'(acc_ack), 64'd0);
    end
    cpu_lock = 1'b0;
    step("unlock");
    chk("unlock_ack", 64'(acc_ack), 64'd1);
    chk("unlock_reg", 64'(write_reg), 64'd10);
    acc_req = 1'b0;
    step("idle5");

    // Asynchronous reset while an ack is showing.
    set_cpu(1'b1, 6'd20, 32'h0000_2020);
    @(posedge clk);
    #2 chk("pre_rst_ack", 64'(cpu_ack), 64'd1);
    chk("pre_rst_wr", 64'(reg_write), 64'd1);
    rst_n = 1'b0;
    #1 chk("async_rst", 64'(dut_vec), 64'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst");
    chk("post_rst_vec", 64'(dut_vec), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
